aec_stream_tx: RTL
==================

AEC_STREAM_TX -- requirements
Module: aec_stream_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning expression buffer size in bytes (power of two, 4..64).
REQ-002 SHALL have parameter TIMEOUT, default 4095, meaning maximum WAIT cycles before timeout.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  load one expression byte into buffer.
REQ-006 wr_data  input  8  ASCII byte to load.
REQ-007 exp_ans  input  7  expected result, sampled on accepted start.
REQ-008 start  input  1  begin transmission of buffered expression.
REQ-009 ascii_out  output  8  ASCII byte to calculator (drives calculator ascii_in).
REQ-010 ready_out  output  1  first-byte marker (drives calculator ready).
REQ-011 valid_in  input  1  calculator result valid.
REQ-012 result_in  input  7  calculator result.
REQ-013 busy  output  1  high in SEND or WAIT.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 pass  output  1  result_q == captured exp_ans; valid from done until next accepted start.
REQ-016 result_q  output  7  captured result_in.
REQ-017 timeout  output  1  sticky; WAIT exceeded TIMEOUT cycles.
REQ-018 overflow  output  1  sticky; write attempted into full buffer.

Function
REQ-019 States SHALL be IDLE, SEND, WAIT, DONE; encoding free.
REQ-020 IDLE: wr_en with count<DEPTH SHALL store wr_data at index count, count+1; with count==DEPTH SHALL drop byte and set overflow.
REQ-021 wr_en outside IDLE SHALL be ignored (no store, no overflow).
REQ-022 IDLE: start with count>0 SHALL latch exp_ans, clear pass/timeout, go SEND; start with count==0 SHALL be ignored.
REQ-023 start outside IDLE SHALL be ignored; wr_en and start in same IDLE cycle: write SHALL occur, start SHALL see pre-write count.
REQ-024 Start sampled at edge T: byte0 on ascii_out with ready_out=1 from T+1; byte i on ascii_out in cycle T+1+i, one byte per cycle, no gaps.
REQ-025 ready_out SHALL be high exactly one cycle per transmission, coincident with byte0.
REQ-026 SEND SHALL end after emitting byte 0x3D ('=') or byte count-1, whichever first; bytes after '=' not sent.
REQ-027 ascii_out SHALL hold last sent byte until the next transmission's byte0.
REQ-028 WAIT entered the cycle after last byte; wait counter starts at 0, increments each WAIT cycle.
REQ-029 valid_in SHALL be sampled only in WAIT; valid_in in IDLE/SEND/DONE ignored.
REQ-030 valid_in=1 in WAIT at edge E: result_q<=result_in, pass<=(result_in==latched exp_ans), state DONE, done=1 in cycle E+1.
REQ-031 Wait counter reaching TIMEOUT without valid_in: timeout<=1, pass<=0, result_q unchanged, go DONE.
REQ-032 valid_in on the same edge the counter reaches TIMEOUT SHALL count as valid (no timeout).
REQ-033 DONE lasts exactly one cycle, SHALL clear count to 0, then IDLE.
REQ-034 overflow SHALL clear only on rst; timeout clears on rst or accepted start.

Reset
REQ-035 rst SHALL force IDLE, count=0, ascii_out=0, ready_out=0, busy=0, done=0, pass=0, result_q=0, timeout=0, overflow=0.
REQ-036 rst mid-SEND or mid-WAIT SHALL abort immediately with no done pulse; buffer contents discarded.
REQ-037 rst SHALL take priority over wr_en, start and valid_in in the same cycle.

Verification
REQ-038 Load "3+4=", exp_ans=7, start at T; result_in=7 with valid_in at T+10 -> ready_out=1 only at T+1; ascii_out 0x33,0x2B,0x34,0x3D at T+1..T+4; done at T+11, pass=1, result_q=7.
REQ-039 Load "9-2=", exp_ans=5; respond result_in=7 -> done=1, pass=0, result_q=7, timeout=0.
REQ-040 Load "1=23" -> only 0x31,0x3D sent; WAIT from T+3.
REQ-041 Write 33 bytes with DEPTH=32 -> overflow=1, count=32; start with empty buffer -> busy stays 0.
REQ-042 No valid_in after send, TIMEOUT=15 -> timeout=1, done pulse 16 cycles after WAIT entry, pass=0.
REQ-043 rst at T+2 during "3+4=" send -> next cycle IDLE, ascii_out=0, no done; fresh load and start transmit normally.

Source files
------------

// File: rtl/aec_stream_tx.sv
// Streams a buffered ASCII expression to a calculator one byte per cycle,
// then waits for its result and compares it against an expected answer.
module aec_stream_tx #(
   parameter int DEPTH   = 32,
   parameter int TIMEOUT = 4095
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic [6:0] exp_ans,
   input  logic       start,
   output logic [7:0] ascii_out,
   output logic       ready_out,
   input  logic       valid_in,
   input  logic [6:0] result_in,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [6:0] result_q,
   output logic       timeout,
   output logic       overflow
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;
   localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [WW-1:0] TMAX = WW'(TIMEOUT);
   localparam logic [7:0]    EQ   = 8'h3D;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]    state;
   logic [CW-1:0] count;
   logic [IW-1:0] idx;
   logic [IW-1:0] nxt_idx;
   logic [WW-1:0] wcnt;
   logic [6:0]    exp_q;
   logic [7:0]    mem [DEPTH];

   logic idle;
   logic wr_ok;
   logic wr_ovf;
   logic go;
   logic last_byte;

   assign idle    = (state == IDLE);
   assign wr_ok   = idle && wr_en && (count != FULL);
   assign wr_ovf  = idle && wr_en && (count == FULL);
   assign go      = idle && start && (count != '0);
   assign nxt_idx = idx + IW'(1);

   // '=' terminates the expression early; otherwise stop at the last stored byte
   assign last_byte = (ascii_out == EQ) ||
                      ({1'b0, idx} == (count - CW'(1)));

   assign busy = (state == SEND) || (state == WAIT);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (!rst && wr_ok)
         mem[count[IW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         idx       <= '0;
         wcnt      <= '0;
         exp_q     <= '0;
         ascii_out <= '0;
         ready_out <= 1'b0;
         pass      <= 1'b0;
         result_q  <= '0;
         timeout   <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         ready_out <= 1'b0;
         unique case (state)
            IDLE: begin
               if (wr_ok)
                  count <= count + CW'(1);
               if (wr_ovf)
                  overflow <= 1'b1;
               if (go) begin
                  exp_q     <= exp_ans;
                  pass      <= 1'b0;
                  timeout   <= 1'b0;
                  ascii_out <= mem[IW'(0)];
                  ready_out <= 1'b1;
                  idx       <= '0;
                  state     <= SEND;
               end
            end
            SEND: begin
               if (last_byte) begin
                  wcnt  <= '0;
                  state <= WAIT;
               end else begin
                  idx       <= nxt_idx;
                  ascii_out <= mem[nxt_idx];
               end
            end
            WAIT: begin
               // a result arriving on the final count still wins
               if (valid_in) begin
                  result_q <= result_in;
                  pass     <= (result_in == exp_q);
                  state    <= DONE;
               end else if (wcnt == TMAX) begin
                  timeout <= 1'b1;
                  pass    <= 1'b0;
                  state   <= DONE;
               end else begin
                  wcnt <= wcnt + WW'(1);
               end
            end
            DONE: begin
               count <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
